tag_ram_nway: RTL

Parameterised N-way set-associative tag store with synchronous read, per-way valid bits, and a registered hit compare. It generalises the single-way tag RAM into one block the cache controller queries once per access. It adds:
- self-clearing of all valid bits after reset or on command;
- tag write, way invalidate and set invalidate operations;
- a one-cycle-latency lookup response with hit way and all stored tags.

---
 rtl/tag_ram_pkg.sv | 8 +
 rtl/ram_sync_read_param.sv | 20 ++
 rtl/tag_ram_nway.sv | 86 ++++++++
 3 files changed

// File: rtl/tag_ram_pkg.sv
// tag_ram_pkg: request op encodings and flush FSM state type for tag_ram_nway
package tag_ram_pkg;
  localparam logic [1:0] OP_LOOKUP  = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_INV_WAY = 2'b10;
  localparam logic [1:0] OP_INV_SET = 2'b11;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/ram_sync_read_param.sv
// ram_sync_read_param: single-port synchronous-read write-first RAM, no reset
module ram_sync_read_param #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [1 << AWIDTH];
  // write data is forwarded to the read port on a write cycle
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata <= wdata;
    end else rdata <= mem[addr];
  end
endmodule

// File: rtl/tag_ram_nway.sv
// tag_ram_nway: N-way set-associative tag store with valid flush and registered hit compare
module tag_ram_nway
  import tag_ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS = 2,
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  output logic                   busy,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [AWIDTH-1:0]      req_addr,
  input  logic [TWIDTH-1:0]      req_tag,
  input  logic [WAYW-1:0]        req_way,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic [WAYW-1:0]        rsp_way,
  output logic                   rsp_multi,
  output logic [WAYS-1:0]        rsp_valids,
  output logic [WAYS*TWIDTH-1:0] rsp_tags
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
  state_e state, state_nx;
  logic [AWIDTH-1:0] cnt, cnt_nx, addr;
  logic acc, is_lookup, vld_wd, lookup_q;
  logic [TWIDTH-1:0] tag_q;
  logic [WAYS-1:0] vld_rd, match, we_t, we_v;
  logic [TWIDTH-1:0] tag_rd [WAYS];
  logic [WAYW-1:0] enc;
  assign busy = state == ST_INIT;
  assign req_ready = state == ST_RUN && !init;
  assign acc = req_valid && req_ready;
  assign is_lookup = acc && req_op == OP_LOOKUP;
  assign addr = busy ? cnt : req_addr;
  assign vld_wd = !busy && req_op == OP_WRITE;
  // flush state and set counter; reset restarts the flush at set 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt <= '0;
      lookup_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      lookup_q <= is_lookup;
    end
  end
  // init restarts the sweep from any state; last set cleared returns to RUN
  always_comb begin
    state_nx = init ? ST_INIT : (busy && cnt == LAST) ? ST_RUN : state;
    cnt_nx = (init || !busy) ? '0 : cnt + 1'b1;
  end
  // compare tag is held for the response cycle
  always_ff @(posedge clock) begin
    if (is_lookup) tag_q <= req_tag;
  end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign we_t[w] = acc && req_op == OP_WRITE && req_way == WAYW'(w);
    assign we_v[w] = busy || (acc && (req_op == OP_INV_SET ||
                     ((req_op == OP_WRITE || req_op == OP_INV_WAY) && req_way == WAYW'(w))));
    ram_sync_read_param #(.AWIDTH(AWIDTH), .DWIDTH(TWIDTH)) u_tag (
      .clock(clock), .we(we_t[w]), .addr(addr), .wdata(req_tag), .rdata(tag_rd[w])
    );
    ram_sync_read_param #(.AWIDTH(AWIDTH), .DWIDTH(1)) u_vld (
      .clock(clock), .we(we_v[w]), .addr(addr), .wdata(vld_wd), .rdata(vld_rd[w])
    );
    assign match[w] = vld_rd[w] && tag_rd[w] == tag_q;
    assign rsp_tags[w*TWIDTH +: TWIDTH] = tag_rd[w];
  end
  // lowest matching way wins
  always_comb begin
    enc = '0;
    for (int i = WAYS - 1; i >= 0; i--) enc = match[i] ? WAYW'(i) : enc;
  end
  assign rsp_valid = lookup_q;
  assign rsp_valids = vld_rd;
  assign rsp_hit = lookup_q && |match;
  assign rsp_way = lookup_q ? enc : '0;
  assign rsp_multi = lookup_q && |(match & (match - WAYS'(1)));
endmodule
